// File: rtl/mem_types_pkg.sv
// Shared types for the icache block-read path: block/word types, the
// responder state encoding and the byte-address helper.
package mem_types_pkg;

  typedef logic [28:0] block_addr_t;
  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE,
    RD0,
    RD1,
    RESP
  } imem_resp_state_t;

  localparam int IMEM_BLOCK_WORDS = 2;

  // Byte address of one word inside a block; pure concatenation, no carry.
  function automatic logic [31:0] wordByteAddr(input block_addr_t blk, input logic off);
    return {blk, off, 2'b00};
  endfunction

endpackage

// File: rtl/imem_responder_watchdog.sv
// RAM stall watchdog: counts consecutive stall cycles of one word read and
// raises a sticky timeout once the count reaches MAX_WAIT_CYCLES.
module imem_watchdog #(
  parameter int MAX_WAIT_CYCLES = 255,
  parameter int WAIT_CNT_WIDTH  = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic count_en,
  input  logic clear,
  output logic timeout
);

  localparam logic [WAIT_CNT_WIDTH-1:0] MAX_CNT  = WAIT_CNT_WIDTH'(MAX_WAIT_CYCLES);
  localparam logic [WAIT_CNT_WIDTH-1:0] LAST_CNT = WAIT_CNT_WIDTH'(MAX_WAIT_CYCLES - 1);

  logic [WAIT_CNT_WIDTH-1:0] r_waitCnt;
  logic                      r_error;
  logic                      w_atMax;
  logic                      w_reachMax;

  assign w_atMax    = (r_waitCnt >= MAX_CNT);
  assign w_reachMax = count_en & ~clear & (r_waitCnt >= LAST_CNT);
  assign timeout    = r_error;

  // Stall counter; saturates at the limit so it can never wrap back to zero.
  always_ff @(posedge CLK) begin
    if (RST)
      r_waitCnt <= '0;
    else if (clear)
      r_waitCnt <= '0;
    else if (count_en && !w_atMax)
      r_waitCnt <= r_waitCnt + 1'b1;
  end

  // Sticky error, set on the stall that brings the count to the limit.
  always_ff @(posedge CLK) begin
    if (RST)
      r_error <= 1'b0;
    else if (w_reachMax)
      r_error <= 1'b1;
  end

endmodule

// File: rtl/imem_responder.sv
// Memory-controller responder for icache 2-word block reads. Each request
// is served by two sequential word reads on the RAM port and answered with
// a one-cycle imem_hit. A requester that changes or drops its address
// mid-fetch aborts the fetch.
// Optional macro IMEM_LAST_BLOCK_BUF_EN adds a one-entry last-block buffer
// that answers a repeated request without touching RAM.
module imem_responder
  import mem_types_pkg::*;
#(
  parameter int MAX_WAIT_CYCLES = 255,
  parameter int WAIT_CNT_WIDTH  = 8
) (
  input  logic                               CLK,
  input  logic                               RST,
  output logic                               DUT_error,
  input  logic                               imem_REN,
  input  block_addr_t                        imem_block_addr,
  output logic                               imem_hit,
  output word_t [IMEM_BLOCK_WORDS-1:0]       imem_load,
  output logic                               ram_REN,
  output logic [31:0]                        ram_addr,
  input  logic                               ram_ready,
  input  word_t                              ram_load,
  input  logic                               buf_flush
);

  imem_resp_state_t r_state;
  imem_resp_state_t w_nextState;
  block_addr_t      r_blkAddr;
  word_t            r_word0;
  word_t            r_word1;

  logic w_match;
  logic w_inRd;
  logic w_hit;
  logic w_countEn;
  logic w_clear;
  logic w_bufHit;

  assign w_match   = imem_REN & (imem_block_addr == r_blkAddr);
  assign w_inRd    = (r_state == RD0) | (r_state == RD1);
  assign w_hit     = (r_state == RESP) & w_match;
  assign w_countEn = w_inRd & w_match & ~ram_ready;
  assign w_clear   = ~w_inRd | ram_ready | ~w_match;

`ifdef IMEM_LAST_BLOCK_BUF_EN
  logic        r_lbValid;
  block_addr_t r_lbAddr;
  logic [63:0] r_lbData;

  assign w_bufHit = imem_REN & r_lbValid & (imem_block_addr == r_lbAddr);

  // Last-block buffer: refilled on every hit; a flush in the same cycle wins.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_lbValid <= 1'b0;
      r_lbAddr  <= '0;
      r_lbData  <= '0;
    end else begin
      if (w_hit) begin
        r_lbAddr <= r_blkAddr;
        r_lbData <= {r_word1, r_word0};
      end
      if (buf_flush)
        r_lbValid <= 1'b0;
      else if (w_hit)
        r_lbValid <= 1'b1;
    end
  end
`else
  logic w_unusedFlush;

  assign w_bufHit      = 1'b0;
  assign w_unusedFlush = buf_flush;
`endif

  // State register.
  always_ff @(posedge CLK) begin
    if (RST)
      r_state <= IDLE;
    else
      r_state <= w_nextState;
  end

  // Next-state logic: a mismatch in a read state aborts back to IDLE.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (w_bufHit)
          w_nextState = RESP;
        else if (imem_REN)
          w_nextState = RD0;
      end
      RD0: begin
        if (!w_match)
          w_nextState = IDLE;
        else if (ram_ready)
          w_nextState = RD1;
      end
      RD1: begin
        if (!w_match)
          w_nextState = IDLE;
        else if (ram_ready)
          w_nextState = RESP;
      end
      RESP:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Address and data capture; data is only taken while the request still matches.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_blkAddr <= '0;
      r_word0   <= '0;
      r_word1   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (imem_REN)
            r_blkAddr <= imem_block_addr;
`ifdef IMEM_LAST_BLOCK_BUF_EN
          if (w_bufHit) begin
            r_word0 <= r_lbData[31:0];
            r_word1 <= r_lbData[63:32];
          end
`endif
        end
        RD0: begin
          if (w_match && ram_ready)
            r_word0 <= ram_load;
        end
        RD1: begin
          if (w_match && ram_ready)
            r_word1 <= ram_load;
        end
        default: ;
      endcase
    end
  end

  // Outputs: RAM request in the read states, hit and block data in RESP only.
  always_comb begin
    ram_REN   = 1'b0;
    ram_addr  = '0;
    imem_hit  = 1'b0;
    imem_load = '0;
    case (r_state)
      RD0: begin
        ram_REN  = 1'b1;
        ram_addr = wordByteAddr(r_blkAddr, 1'b0);
      end
      RD1: begin
        ram_REN  = 1'b1;
        ram_addr = wordByteAddr(r_blkAddr, 1'b1);
      end
      RESP: begin
        imem_hit = w_hit;
        if (w_hit)
          imem_load = {r_word1, r_word0};
      end
      default: ;
    endcase
  end

  imem_watchdog #(
    .MAX_WAIT_CYCLES(MAX_WAIT_CYCLES),
    .WAIT_CNT_WIDTH (WAIT_CNT_WIDTH)
  ) u_watchdog (
    .CLK     (CLK),
    .RST     (RST),
    .count_en(w_countEn),
    .clear   (w_clear),
    .timeout (DUT_error)
  );

endmodule

// File: tb/tb_imem_responder.sv
// Testbench for imem_responder: a per-cycle vector table for the main read
// flows plus hand-written sequences for timeout, reset mid-fetch and the
// optional last-block buffer (IMEM_LAST_BLOCK_BUF_EN).
module tb_imem_responder;

  typedef struct {
    logic        ren;
    logic [28:0] addr;
    logic        ready;
    logic [31:0] load;
    logic        eHit;
    logic [63:0] eLoad;
    logic        eRen;
    logic [31:0] eAddr;
    logic        eErr;
  } vec_t;

`ifdef IMEM_LAST_BLOCK_BUF_EN
  localparam logic LB_BUILD = 1'b1;
`else
  localparam logic LB_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        dutError;
  logic        imemRen;
  logic [28:0] imemBlockAddr;
  logic        imemHit;
  logic [63:0] imemLoad;
  logic        ramRen;
  logic [31:0] ramAddr;
  logic        ramReady;
  logic [31:0] ramLoad;
  logic        bufFlush;

  int checks   = 0;
  int failures = 0;

  vec_t vecs[$];

  always #5 clk = ~clk;

  imem_responder #(
    .MAX_WAIT_CYCLES(4),
    .WAIT_CNT_WIDTH (8)
  ) dut (
    .CLK            (clk),
    .RST            (rst),
    .DUT_error      (dutError),
    .imem_REN       (imemRen),
    .imem_block_addr(imemBlockAddr),
    .imem_hit       (imemHit),
    .imem_load      (imemLoad),
    .ram_REN        (ramRen),
    .ram_addr       (ramAddr),
    .ram_ready      (ramReady),
    .ram_load       (ramLoad),
    .buf_flush      (bufFlush)
  );

  task automatic addVec(input logic ren, input logic [28:0] addr, input logic ready,
                        input logic [31:0] load, input logic eHit, input logic [63:0] eLoad,
                        input logic eRen, input logic [31:0] eAddr, input logic eErr);
    vec_t v;
    v.ren = ren; v.addr = addr; v.ready = ready; v.load = load;
    v.eHit = eHit; v.eLoad = eLoad; v.eRen = eRen; v.eAddr = eAddr; v.eErr = eErr;
    vecs.push_back(v);
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic r, input logic ren, input logic [28:0] addr,
                               input logic ready, input logic [31:0] load);
    @(posedge clk);
    #1;
    rst           = r;
    imemRen       = ren;
    imemBlockAddr = addr;
    ramReady      = ready;
    ramLoad       = load;
  endtask

  task automatic checkOne(input string name, input int idx,
                          input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s step=%0d got=0x%0h expected=0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic checkOutput(input string tag, input int idx, input logic eHit,
                             input logic [63:0] eLoad, input logic eRen,
                             input logic [31:0] eAddr, input logic eErr);
    checkOne({tag, ".imem_hit"},  idx, {63'd0, imemHit},  {63'd0, eHit});
    checkOne({tag, ".imem_load"}, idx, imemLoad,          eLoad);
    checkOne({tag, ".ram_REN"},   idx, {63'd0, ramRen},   {63'd0, eRen});
    checkOne({tag, ".ram_addr"},  idx, {32'd0, ramAddr},  {32'd0, eAddr});
    checkOne({tag, ".DUT_error"}, idx, {63'd0, dutError}, {63'd0, eErr});
  endtask

  initial begin
    rst = 1'b1; imemRen = 1'b0; imemBlockAddr = '0;
    ramReady = 1'b0; ramLoad = '0; bufFlush = LB_BUILD;

    // Zero-stall read of block 0x10; hit three cycles after the request.
    addVec(1, 29'h10, 0, 32'h0,        0, 64'h0, 0, 32'h0,  0);
    addVec(1, 29'h10, 1, 32'hAAAA0000, 0, 64'h0, 1, 32'h80, 0);
    addVec(1, 29'h10, 1, 32'hBBBB0001, 0, 64'h0, 1, 32'h84, 0);
    addVec(1, 29'h10, 0, 32'h0,        1, 64'hBBBB0001_AAAA0000, 0, 32'h0, 0);
    addVec(0, 29'h0,  0, 32'h0,        0, 64'h0, 0, 32'h0,  0);
    // Three stall cycles per word on block 0x55; hit nine cycles after the request.
    addVec(1, 29'h55, 0, 32'h0, 0, 64'h0, 0, 32'h0, 0);
    for (int i = 0; i < 3; i++) addVec(1, 29'h55, 0, 32'h0, 0, 64'h0, 1, 32'h2A8, 0);
    addVec(1, 29'h55, 1, 32'h11111111, 0, 64'h0, 1, 32'h2A8, 0);
    for (int i = 0; i < 3; i++) addVec(1, 29'h55, 0, 32'h0, 0, 64'h0, 1, 32'h2AC, 0);
    addVec(1, 29'h55, 1, 32'h22222222, 0, 64'h0, 1, 32'h2AC, 0);
    addVec(1, 29'h55, 0, 32'h0, 1, 64'h22222222_11111111, 0, 32'h0, 0);
    addVec(0, 29'h0,  0, 32'h0, 0, 64'h0, 0, 32'h0, 0);
    // Address switches 0x10 -> 0x20 while in RD1: abort, then fresh fetch of 0x20.
    addVec(1, 29'h10, 0, 32'h0,        0, 64'h0, 0, 32'h0,   0);
    addVec(1, 29'h10, 1, 32'hDEAD0000, 0, 64'h0, 1, 32'h80,  0);
    addVec(1, 29'h20, 1, 32'hDEAD0001, 0, 64'h0, 1, 32'h84,  0);
    addVec(1, 29'h20, 0, 32'h0,        0, 64'h0, 0, 32'h0,   0);
    addVec(1, 29'h20, 1, 32'hCCCC0000, 0, 64'h0, 1, 32'h100, 0);
    addVec(1, 29'h20, 1, 32'hCCCC0001, 0, 64'h0, 1, 32'h104, 0);
    addVec(1, 29'h20, 0, 32'h0,        1, 64'hCCCC0001_CCCC0000, 0, 32'h0, 0);
    addVec(0, 29'h0,  0, 32'h0,        0, 64'h0, 0, 32'h0,   0);
    // Top block address, then a back-to-back request withdrawn in RESP.
    addVec(1, 29'h1FFFFFFF, 0, 32'h0,        0, 64'h0, 0, 32'h0,        0);
    addVec(1, 29'h1FFFFFFF, 1, 32'h12345678, 0, 64'h0, 1, 32'hFFFFFFF8, 0);
    addVec(1, 29'h1FFFFFFF, 1, 32'h9ABCDEF0, 0, 64'h0, 1, 32'hFFFFFFFC, 0);
    addVec(1, 29'h1FFFFFFF, 0, 32'h0,        1, 64'h9ABCDEF0_12345678, 0, 32'h0, 0);
    addVec(1, 29'h7, 0, 32'h0,        0, 64'h0, 0, 32'h0,  0);
    addVec(1, 29'h7, 1, 32'h0A0A0A0A, 0, 64'h0, 1, 32'h38, 0);
    addVec(1, 29'h7, 1, 32'h0B0B0B0B, 0, 64'h0, 1, 32'h3C, 0);
    addVec(0, 29'h7, 0, 32'h0,        0, 64'h0, 0, 32'h0,  0);
    addVec(0, 29'h0, 0, 32'h0,        0, 64'h0, 0, 32'h0,  0);

    // Reset state.
    applyStimulus(1, 0, 29'h0, 0, 32'h0);
    applyStimulus(1, 0, 29'h0, 0, 32'h0);
    @(negedge clk);
    checkOutput("reset", 0, 0, 64'h0, 0, 32'h0, 0);

    // Table-driven main flows.
    foreach (vecs[i]) begin
      applyStimulus(0, vecs[i].ren, vecs[i].addr, vecs[i].ready, vecs[i].load);
      @(negedge clk);
      checkOutput("tbl", i, vecs[i].eHit, vecs[i].eLoad, vecs[i].eRen, vecs[i].eAddr, vecs[i].eErr);
    end

    // Timeout with limit 4: error clear after 3 stalls, set after 6, sticky past a hit.
    applyStimulus(0, 1, 29'h40, 0, 32'h0);
    for (int i = 1; i <= 7; i++) begin
      applyStimulus(0, 1, 29'h40, 0, 32'h0);
      @(negedge clk);
      checkOne("to.ram_addr", i, {32'd0, ramAddr}, 64'h200);
      if (i == 4) checkOne("to.errEarly", i, {63'd0, dutError}, 64'd0);
      if (i == 7) checkOne("to.errSet",   i, {63'd0, dutError}, 64'd1);
    end
    applyStimulus(0, 1, 29'h40, 1, 32'h0F0F0000);
    applyStimulus(0, 1, 29'h40, 1, 32'h0F0F0001);
    applyStimulus(0, 1, 29'h40, 0, 32'h0);
    @(negedge clk);
    checkOutput("toHit", 0, 1, 64'h0F0F0001_0F0F0000, 0, 32'h0, 1);
    applyStimulus(0, 0, 29'h0, 0, 32'h0);
    @(negedge clk);
    checkOutput("toIdle", 0, 0, 64'h0, 0, 32'h0, 1);

    // Reset while in RD0 with ram_ready high abandons the fetch and clears the error.
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    applyStimulus(1, 1, 29'h10, 1, 32'hFFFF0000);
    @(negedge clk);
    checkOutput("rstRd0", 0, 0, 64'h0, 1, 32'h80, 1);
    applyStimulus(0, 0, 29'h0, 0, 32'h0);
    @(negedge clk);
    checkOutput("rstAfter", 0, 0, 64'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    applyStimulus(0, 1, 29'h10, 1, 32'h00000005);
    applyStimulus(0, 1, 29'h10, 1, 32'h00000006);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    @(negedge clk);
    checkOutput("rstRefetch", 0, 1, 64'h00000006_00000005, 0, 32'h0, 0);
    applyStimulus(0, 0, 29'h0, 0, 32'h0);

`ifdef IMEM_LAST_BLOCK_BUF_EN
    // Repeat of the last block is served from the buffer; a flush forces a RAM fetch.
    bufFlush = 1'b0;
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    applyStimulus(0, 1, 29'h10, 1, 32'hAAAA0000);
    applyStimulus(0, 1, 29'h10, 1, 32'hBBBB0001);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    @(negedge clk);
    checkOutput("lbFill", 0, 1, 64'hBBBB0001_AAAA0000, 0, 32'h0, 0);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    @(negedge clk);
    checkOutput("lbIdle", 0, 0, 64'h0, 0, 32'h0, 0);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    @(negedge clk);
    checkOutput("lbHit", 0, 1, 64'hBBBB0001_AAAA0000, 0, 32'h0, 0);
    applyStimulus(0, 0, 29'h0, 0, 32'h0);
    bufFlush = 1'b1;
    applyStimulus(0, 0, 29'h0, 0, 32'h0);
    bufFlush = 1'b0;
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    @(negedge clk);
    checkOutput("lbFlushed", 0, 0, 64'h0, 1, 32'h80, 0);
    applyStimulus(0, 1, 29'h10, 1, 32'h1);
    applyStimulus(0, 1, 29'h10, 1, 32'h2);
    applyStimulus(0, 1, 29'h10, 0, 32'h0);
    @(negedge clk);
    checkOutput("lbRefetch", 0, 1, 64'h00000002_00000001, 0, 32'h0, 0);
    applyStimulus(0, 0, 29'h0, 0, 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
